bt_pipe_initiator: RTL and testbench
====================================

# bt_pipe_initiator

Synthesizable initiator for the block-throttled pipe handshake. It drives write strobes and data into a pipe-in consumer, or read strobes into a pipe-out producer and checks the returned data. Transfers are issued in whole blocks, each gated by the target's ready flag. It is used for on-chip loopback self-test and benchmarking of the pipe checkers without a host link, on the same okClk domain as the endpoints.

## Interface
- `BLOCK_WORDS`, 256: words per block; power of two, range 2..1024.
- `CNT_W`, 16: width of the block-count request.
- `clk` in 1: single clock (okClk domain).
- `reset_n` in 1: reset; asynchronous and active-low.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `abort` in 1: synchronous cancel of the transfer in progress.
- `dir` in 1: 0 = write toward the pipe-in side; 1 = read from the pipe-out side. Sampled at start.
- `pattern` in 1: 0 = counter, 1 = LFSR32. Sampled at start.
- `seed` in 32: generator start value. Sampled at start.
- `num_blocks` in CNT_W: number of blocks to transfer. Sampled at start.
- `pipe_in_ready` in 1: target can accept one full block.
- `pipe_in_write` out 1: write strobe.
- `pipe_in_data` out 32: data accompanying the write strobe.
- `pipe_out_ready` in 1: target can supply one full block.
- `pipe_out_read` out 1: read strobe.
- `pipe_out_data` in 32: valid one cycle after `pipe_out_read`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at normal completion.
- `word_count` out 32: strobes issued since the last start.
- `error_count` out 32: read mismatches; saturates at 32'hFFFFFFFF.

## Operation
- States: IDLE, WAIT_RDY, BURST, DRAIN, DONE.
- **IDLE**
  - On `start`, latch dir, pattern, seed and num_blocks.
  - Clear `word_count` and `error_count`. Load the generator.
  - If num_blocks==0, go to DONE. Otherwise go to WAIT_RDY.
- **WAIT_RDY**
  - Sample the ready flag selected by dir.
  - When it is high, go to BURST. No strobe is issued in this cycle.
- **BURST**
  - Assert exactly BLOCK_WORDS consecutive strobes, one per cycle.
  - Ready is ignored mid-block: ready guarantees a whole block.
  - After the last strobe of a block:
    - If blocks remain, go to WAIT_RDY.
    - Else if dir=1, go to DRAIN.
    - Else go to DONE.
- **DRAIN**: one cycle, used to compare the final read word. Then go to DONE.
- **DONE**: assert `done` for one cycle, then go to IDLE.
- **Generator**
  - Counter pattern: word k = seed + k, mod 2^32.
  - LFSR32 pattern: next = {w[30:0], w[31]^w[21]^w[1]^w[0]}. A seed of 0 is replaced by 32'h1.
  - The generator advances on each strobe.
- **Write path**: `pipe_in_data` equals the generator value during each write strobe.
- **Read path**
  - The expected value is registered alongside the strobe.
  - In the cycle after the strobe, compare against `pipe_out_data`. On mismatch, increment `error_count` (saturating).
- **abort**
  - Valid in any non-IDLE state; it has priority over all other transitions.
  - Next cycle: state is IDLE and strobes are low. No `done` pulse.
  - Counters hold their values.
  - A compare pending from a strobe in the abort cycle is discarded.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: start wins.

## Timing
- Reset values: state=IDLE; `pipe_in_write`=0, `pipe_in_data`=0, `pipe_out_read`=0; `busy`=0; `done`=0; `word_count`=0; `error_count`=0.
- All outputs are registered.
- Start to first strobe: start sampled at edge N, WAIT_RDY at N+1, first strobe at N+2 if ready is already high.
- Per-block overhead: one WAIT_RDY cycle.
  - Throughput with ready held high: BLOCK_WORDS/(BLOCK_WORDS+1).
- Completion:
  - Writes: `done` one cycle after the last strobe.
  - Reads: `done` two cycles after the last strobe (DRAIN, then DONE).
- `word_count` increments in the same cycle each strobe is asserted.
- If ready is low in WAIT_RDY, wait indefinitely with no timeout.
- `reset_n` asserted mid-burst forces all outputs to their reset values immediately (asynchronous).

## Structure
- Package `bt_pipe_pkg` holds:
  - the state enum;
  - pattern codes PAT_COUNTER=0, PAT_LFSR=1;
  - the LFSR tap constant;
  - the zero-seed substitute 32'h1.
- One sub-module, `pipe_pattern_gen`:
  - load/advance inputs and a 32-bit value output;
  - shared with the read-path expectation register.

## Test plan
- **Counter write**: BLOCK_WORDS=4, dir=0, pattern=0, seed=32'h10, num_blocks=2, ready high.
  - Expect data 10..17 across two 4-strobe bursts separated by one idle cycle.
  - Expect word_count=8 and done 1 cycle after the last strobe.
- **Ready throttle**: `pipe_in_ready` low for 5 cycles after block 1.
  - Expect no strobe while low; block 2 starts 1 cycle after ready rises.
  - A ready drop mid-block does not break the burst.
- **LFSR read loopback**: dir=1, pattern=1, seed=0, against an ideal model returning the same sequence one cycle late.
  - Expect first expected word 32'h1 and error_count=0.
  - Expect done 2 cycles after the last strobe.
- **Read mismatch**: corrupt words 3 and 7 of an 8-word read.
  - Expect error_count=2.
- **Zero blocks**: num_blocks=0.
  - Expect done pulse with no strobes and word_count=0.
- **Abort and reset mid-burst**
  - abort after 3 strobes: no strobe next cycle, busy=0, no done, word_count=3.
  - reset_n low mid-burst: all outputs 0 immediately.

Source files
------------

// File: rtl/bt_pipe_initiator_pkg.sv
// -----------------------------------------------------------------------------
// bt_pipe_pkg
// Shared types and constants for the block-throttled pipe initiator:
//   state_t      - initiator FSM states (also exported on the debug port)
//   pattern_t    - data pattern select codes
//   LFSR_TAPS    - feedback taps of the 32-bit LFSR (bits 31, 21, 1, 0)
//   LFSR_ZERO_SEED - substitute for an all-zero LFSR seed (lock-up state)
//   gen_seed / gen_next - generator load and advance functions
// -----------------------------------------------------------------------------
package bt_pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_BURST    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  typedef enum logic {
    PAT_COUNTER = 1'b0,
    PAT_LFSR    = 1'b1
  } pattern_t;

  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SEED = 32'h0000_0001;

  // All-zero is the LFSR's stuck state, so it is never loaded.
  function automatic logic [31:0] gen_seed(input pattern_t p, input logic [31:0] s);
    if ((p == PAT_LFSR) && (s == 32'h0)) return LFSR_ZERO_SEED;
    return s;
  endfunction

  function automatic logic [31:0] gen_next(input pattern_t p, input logic [31:0] w);
    if (p == PAT_LFSR) return {w[30:0], ^(w & LFSR_TAPS)};
    return w + 32'd1;
  endfunction

endpackage

// File: rtl/bt_pipe_initiator_if.sv
// -----------------------------------------------------------------------------
// bt_pipe_initiator_if
// Pipe-side bus between the initiator and its pipe-in / pipe-out targets.
//
// Handshake: a target raises *_ready only when it can take (pipe-in) or
// supply (pipe-out) one complete block. The initiator looks at ready only
// before a block; once a block starts it issues one strobe per cycle for the
// whole block regardless of ready. Read data returns on pipe_out_data in the
// cycle after each pipe_out_read strobe.
//
// Modports: master = initiator, slave = target.
// -----------------------------------------------------------------------------
interface bt_pipe_initiator_if;
  logic        pipe_in_ready;
  logic        pipe_in_write;
  logic [31:0] pipe_in_data;
  logic        pipe_out_ready;
  logic        pipe_out_read;
  logic [31:0] pipe_out_data;

  modport master (
    input  pipe_in_ready,
    output pipe_in_write,
    output pipe_in_data,
    input  pipe_out_ready,
    output pipe_out_read,
    input  pipe_out_data
  );

  modport slave (
    output pipe_in_ready,
    input  pipe_in_write,
    input  pipe_in_data,
    output pipe_out_ready,
    input  pipe_out_read,
    output pipe_out_data
  );
endinterface

// File: rtl/bt_pipe_initiator_pattern_gen.sv
// -----------------------------------------------------------------------------
// pipe_pattern_gen
// Registered data-pattern generator (counter or LFSR32). The pattern is
// captured together with the seed on load so the caller need not hold it.
// Ports:
//   clk, reset_n   - clock, async active-low reset
//   load           - capture pattern and seed (seed 0 -> 1 for LFSR)
//   advance        - step to the next word
//   pattern, seed  - values captured on load
//   value          - current generator word
// -----------------------------------------------------------------------------
module pipe_pattern_gen
  import bt_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  input  pattern_t    pattern,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  pattern_t    r_pattern;
  logic [31:0] r_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= PAT_COUNTER;
      r_value   <= 32'h0;
    end else if (load) begin
      r_pattern <= pattern;
      r_value   <= gen_seed(pattern, seed);
    end else if (advance) begin
      r_value   <= gen_next(r_pattern, r_value);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/bt_pipe_initiator.sv
// -----------------------------------------------------------------------------
// bt_pipe_initiator
// Block-throttled pipe initiator for loopback self-test / benchmarking.
// Writes generated data into a pipe-in target, or reads from a pipe-out target
// and counts mismatches against the generated sequence.
// Ports:
//   clk, reset_n   - clock, async active-low reset
//   start, abort   - one-cycle start request (IDLE only) / synchronous cancel
//   dir, pattern, seed, num_blocks - transfer setup, sampled at start
//   pipe           - pipe bus (master side)
//   busy, done     - not-IDLE flag / one-cycle completion pulse
//   word_count     - strobes issued since last start
//   error_count    - saturating read-mismatch count
//   dbg_state      - current FSM state
// -----------------------------------------------------------------------------
module bt_pipe_initiator
  import bt_pipe_pkg::*;
#(
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                dir,
  input  logic                pattern,
  input  logic [31:0]         seed,
  input  logic [CNT_W-1:0]    num_blocks,
  bt_pipe_initiator_if.master pipe,
  output logic                busy,
  output logic                done,
  output logic [31:0]         word_count,
  output logic [31:0]         error_count,
  output state_t              dbg_state
);

  localparam int                BEAT_W    = $clog2(BLOCK_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  state_t             r_state;
  logic               r_dir;
  logic [CNT_W-1:0]   r_blocks_left;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_in_write;
  logic [31:0]        r_in_data;
  logic               r_out_read;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_word;
  logic [31:0]        r_err;
  logic [31:0]        r_exp;       // expectation issued with the read strobe
  logic [31:0]        r_cmp_exp;   // same, aligned with returning data
  logic               r_cmp_valid;

  logic               w_ready;
  logic               w_last_beat;
  logic               w_issue;
  logic               w_load;
  logic [31:0]        w_gen;

  always_comb begin
    w_ready     = r_dir ? pipe.pipe_out_ready : pipe.pipe_in_ready;
    w_last_beat = (r_beat == LAST_BEAT);
    w_load      = (r_state == ST_IDLE) && start;
    w_issue     = 1'b0;
    if (!abort) begin
      case (r_state)
        ST_WAIT_RDY: w_issue = w_ready;
        ST_BURST:    w_issue = !w_last_beat;
        default:     w_issue = 1'b0;
      endcase
    end
  end

  pipe_pattern_gen u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .advance (w_issue),
    .pattern (pattern_t'(pattern)),
    .seed    (seed),
    .value   (w_gen)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_dir         <= 1'b0;
      r_blocks_left <= '0;
      r_beat        <= '0;
      r_in_write    <= 1'b0;
      r_in_data     <= 32'h0;
      r_out_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_word        <= 32'h0;
      r_err         <= 32'h0;
      r_exp         <= 32'h0;
      r_cmp_exp     <= 32'h0;
      r_cmp_valid   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_in_write <= 1'b0;
      r_out_read <= 1'b0;

      // Read data for a strobe arrives one cycle later; a strobe visible in
      // the abort cycle never gets compared.
      r_cmp_valid <= r_out_read & ~abort;
      r_cmp_exp   <= r_exp;
      if (r_cmp_valid && (pipe.pipe_out_data != r_cmp_exp) && (r_err != 32'hFFFF_FFFF))
        r_err <= r_err + 32'd1;

      if (w_issue) begin
        r_word <= r_word + 32'd1;
        if (r_dir) begin
          r_out_read <= 1'b1;
          r_exp      <= w_gen;
        end else begin
          r_in_write <= 1'b1;
          r_in_data  <= w_gen;
        end
      end

      if ((r_state != ST_IDLE) && abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_dir         <= dir;
              r_blocks_left <= num_blocks;
              r_beat        <= '0;
              r_word        <= 32'h0;
              r_err         <= 32'h0;
              r_busy        <= 1'b1;
              if (num_blocks == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_WAIT_RDY;
              end
            end
          end
          ST_WAIT_RDY: begin
            if (w_ready) begin
              r_state <= ST_BURST;
              r_beat  <= '0;
            end
          end
          ST_BURST: begin
            if (w_last_beat) begin
              r_blocks_left <= r_blocks_left - CNT_W'(1);
              if (r_blocks_left != CNT_W'(1)) begin
                r_state <= ST_WAIT_RDY;
              end else if (r_dir) begin
                r_state <= ST_DRAIN;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
          ST_DRAIN: begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pipe.pipe_in_write = r_in_write;
  assign pipe.pipe_in_data  = r_in_data;
  assign pipe.pipe_out_read = r_out_read;
  assign busy               = r_busy;
  assign done               = r_done;
  assign word_count         = r_word;
  assign error_count        = r_err;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_bt_pipe_initiator.sv
// -----------------------------------------------------------------------------
// tb_bt_pipe_initiator
// Directed bench for bt_pipe_initiator with BLOCK_WORDS=4. Includes a pipe-out
// target that returns a hand-computed LFSR sequence one cycle after each read,
// with optional per-word corruption.
// -----------------------------------------------------------------------------
module tb_bt_pipe_initiator;
  import bt_pipe_pkg::*;

  localparam int BW    = 4;
  localparam int CNT_W = 16;

  // LFSR sequence from seed 1 (seed 0 is replaced by 1), worked by hand.
  localparam logic [31:0] LFSR_TAB [8] = '{
    32'h0000_0001, 32'h0000_0003, 32'h0000_0006, 32'h0000_000D,
    32'h0000_001B, 32'h0000_0036, 32'h0000_006D, 32'h0000_00DB
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             start;
  logic             abort;
  logic             dir;
  logic             pattern;
  logic [31:0]      seed;
  logic [CNT_W-1:0] num_blocks;
  logic             busy;
  logic             done;
  logic [31:0]      word_count;
  logic [31:0]      error_count;
  state_t           dbg_state;

  bt_pipe_initiator_if bus ();

  bt_pipe_initiator #(.BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .dir         (dir),
    .pattern     (pattern),
    .seed        (seed),
    .num_blocks  (num_blocks),
    .pipe        (bus.master),
    .busy        (busy),
    .done        (done),
    .word_count  (word_count),
    .error_count (error_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- pipe-out target model ----------------
  logic [31:0] m_idx   = 32'h0;
  logic [31:0] rd_base = 32'h0;
  logic [7:0]  corrupt = 8'h0;
  logic [31:0] m_rel;
  assign m_rel = m_idx - rd_base;

  always @(posedge clk) begin
    if (bus.pipe_out_read) begin
      bus.pipe_out_data <= LFSR_TAB[m_rel[2:0]] ^ (corrupt[m_rel[2:0]] ? 32'hDEAD_0000 : 32'h0);
      m_idx             <= m_idx + 32'd1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write"}, 32'(bus.pipe_in_write), 32'd0);
    chk({tag, "_wdata"}, bus.pipe_in_data, 32'd0);
    chk({tag, "_read"},  32'(bus.pipe_out_read), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_wc"},    word_count, 32'd0);
    chk({tag, "_ec"},    error_count, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic d, input logic p, input logic [31:0] s,
                            input logic [CNT_W-1:0] n);
    dir        = d;
    pattern    = p;
    seed       = s;
    num_blocks = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; pattern = 1'b0;
    seed = 32'h0; num_blocks = '0;
    bus.pipe_in_ready = 1'b0; bus.pipe_out_ready = 1'b0;

    repeat (3) tick();
    chk_reset_outputs("reset");
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    tick();

    // Counter write, two blocks, ready held high
    bus.pipe_in_ready = 1'b1;
    start_xfer(1'b0, 1'b0, 32'h10, 16'd2);
    chk("cw_busy", 32'(busy), 32'd1);
    chk("cw_wait_nostrobe", 32'(bus.pipe_in_write), 32'd0);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < BW; k++) begin
        tick();
        chk("cw_write", 32'(bus.pipe_in_write), 32'd1);
        chk("cw_data", bus.pipe_in_data, 32'h10 + 32'(b * BW + k));
        chk("cw_wc", word_count, 32'(b * BW + k + 1));
      end
      tick();
      chk("cw_gap_write", 32'(bus.pipe_in_write), 32'd0);
      chk("cw_done", 32'(done), 32'(b == 1));
    end
    chk("cw_wc_final", word_count, 32'd8);
    tick();
    chk("cw_done_clr", 32'(done), 32'd0);
    chk("cw_idle", 32'(busy), 32'd0);

    // Ready throttle: drop mid-block, hold low after block 1
    start_xfer(1'b0, 1'b0, 32'h100, 16'd2);
    for (int k = 0; k < BW; k++) begin
      tick();
      chk("rt_write1", 32'(bus.pipe_in_write), 32'd1);
      chk("rt_data1", bus.pipe_in_data, 32'h100 + 32'(k));
      if (k == 1) bus.pipe_in_ready = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rt_stall_write", 32'(bus.pipe_in_write), 32'd0);
      chk("rt_stall_busy", 32'(busy), 32'd1);
    end
    chk("rt_stall_wc", word_count, 32'd4);
    bus.pipe_in_ready = 1'b1;
    for (int k = 0; k < BW; k++) begin
      tick();
      chk("rt_write2", 32'(bus.pipe_in_write), 32'd1);
      chk("rt_data2", bus.pipe_in_data, 32'h104 + 32'(k));
    end
    tick();
    chk("rt_done", 32'(done), 32'd1);
    chk("rt_wc", word_count, 32'd8);
    tick();
    chk("rt_idle", 32'(busy), 32'd0);

    // LFSR read loopback, seed 0, ideal target
    bus.pipe_out_ready = 1'b1;
    corrupt = 8'h00;
    rd_base = m_idx;
    start_xfer(1'b1, 1'b1, 32'h0, 16'd2);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < BW; k++) begin
        tick();
        chk("lr_read", 32'(bus.pipe_out_read), 32'd1);
        chk("lr_nowrite", 32'(bus.pipe_in_write), 32'd0);
      end
      tick();
      chk("lr_gap_read", 32'(bus.pipe_out_read), 32'd0);
      chk("lr_gap_done", 32'(done), 32'd0);
    end
    chk("lr_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    tick();
    chk("lr_done", 32'(done), 32'd1);
    chk("lr_ec", error_count, 32'd0);
    chk("lr_wc", word_count, 32'd8);
    tick();
    chk("lr_idle", 32'(busy), 32'd0);

    // Read mismatch on words 3 and 7
    corrupt = 8'b1000_1000;
    rd_base = m_idx;
    start_xfer(1'b1, 1'b1, 32'h1, 16'd2);
    repeat (2 * BW + 2) tick();
    chk("mm_drain_ec", error_count, 32'd1);
    tick();
    chk("mm_done", 32'(done), 32'd1);
    chk("mm_ec", error_count, 32'd2);
    tick();
    corrupt = 8'h00;

    // Zero blocks
    start_xfer(1'b0, 1'b0, 32'h55, 16'd0);
    chk("zb_done", 32'(done), 32'd1);
    chk("zb_write", 32'(bus.pipe_in_write), 32'd0);
    chk("zb_read", 32'(bus.pipe_out_read), 32'd0);
    chk("zb_wc", word_count, 32'd0);
    chk("zb_ec_cleared", error_count, 32'd0);
    tick();
    chk("zb_done_clr", 32'(done), 32'd0);
    chk("zb_idle", 32'(busy), 32'd0);

    // Abort after three strobes
    start_xfer(1'b0, 1'b0, 32'h20, 16'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ab_write", 32'(bus.pipe_in_write), 32'd1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_write_low", 32'(bus.pipe_in_write), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_wc", word_count, 32'd3);
    chk("ab_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    chk("ab_no_late_done", 32'(done), 32'd0);
    chk("ab_wc_hold", word_count, 32'd3);

    // start+abort together in IDLE, then async reset mid-burst
    dir = 1'b0; pattern = 1'b0; seed = 32'h30; num_blocks = 16'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd1);
    tick();
    chk("sa_data0", bus.pipe_in_data, 32'h30);
    tick();
    chk("sa_data1", bus.pipe_in_data, 32'h31);
    chk("sa_wc", word_count, 32'd2);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_write", 32'(bus.pipe_in_write), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
